// File: rtl/lsu_bus_ctrl.sv
// Load/store bus controller: one word-aligned valid/ready bus access per
// execute-stage request, with lane steering, load extension and timeout.
module lsu_bus_ctrl #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] addr,
  input  logic [2:0]  is_load,
  input  logic [2:0]  is_store,
  input  logic [31:0] wdata,
  output logic        out_valid,
  output logic [31:0] out_rdata,
  output logic        out_err,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  output logic        mem_req_wen,
  output logic [31:0] mem_req_wdata,
  output logic [3:0]  mem_req_wmask,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_rdata
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    ld_q, ld_d;
  logic [1:0]    off_q, off_d;
  logic [31:0]   req_addr_q, req_addr_d;
  logic          req_wen_q, req_wen_d;
  logic [31:0]   req_wdata_q, req_wdata_d;
  logic [3:0]    req_wmask_q, req_wmask_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  logic        ld_none, st_none;
  logic        ld_ok, st_ok;
  logic        is_half, is_word;
  logic        misal, noop, bad;
  logic [3:0]  st_mask;
  logic [31:0] st_data;
  logic [31:0] lane;
  logic [15:0] half;
  logic [31:0] ld_data;
  logic        tmo;

  assign ld_none = is_load == 3'b111;
  assign st_none = is_store == 3'b111;
  assign ld_ok   = is_load inside {3'b000, 3'b001, 3'b010,
                                   3'b100, 3'b101};
  assign st_ok   = is_store inside {3'b000, 3'b001, 3'b010};

  assign is_half = (ld_none ? 1'b0 : (is_load[1:0] == 2'b01))
                 | (is_store == 3'b001);
  assign is_word = (is_load == 3'b010) | (is_store == 3'b010);
  assign misal   = (is_half & addr[0])
                 | (is_word & (addr[1:0] != 2'b00));

  assign noop = ld_none & st_none;
  assign bad  = (!ld_none & !st_none)
              | (!ld_none & !ld_ok)
              | (!st_none & !st_ok)
              | misal;

  always_comb begin
    st_mask = 4'b0000;
    st_data = 32'h0;
    unique case (1'b1)
      is_store == 3'b000: begin
        st_mask = 4'b0001 << addr[1:0];
        st_data = {4{wdata[7:0]}};
      end
      is_store == 3'b001: begin
        st_mask = addr[1] ? 4'b1100 : 4'b0011;
        st_data = {2{wdata[15:0]}};
      end
      is_store == 3'b010: begin
        st_mask = 4'b1111;
        st_data = wdata;
      end
      default: ;
    endcase
  end

  // Byte lane lands in bits [7:0] after shifting by the latched offset.
  assign lane = mem_resp_rdata >> {off_q, 3'b000};
  assign half = off_q[1] ? mem_resp_rdata[31:16]
                         : mem_resp_rdata[15:0];

  always_comb begin
    ld_data = 32'h0;
    unique case (1'b1)
      ld_q == 3'b000: ld_data = {{24{lane[7]}}, lane[7:0]};
      ld_q == 3'b100: ld_data = {24'h0, lane[7:0]};
      ld_q == 3'b001: ld_data = {{16{half[15]}}, half};
      ld_q == 3'b101: ld_data = {16'h0, half};
      ld_q == 3'b010: ld_data = mem_resp_rdata;
      default: ;
    endcase
  end

  assign tmo = cnt_q == CNT_LAST;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ld_d        = ld_q;
    off_d       = off_q;
    req_addr_d  = req_addr_q;
    req_wen_d   = req_wen_q;
    req_wdata_d = req_wdata_q;
    req_wmask_d = req_wmask_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          ld_d  = is_load;
          off_d = addr[1:0];
          if (noop || bad) begin
            state_d = S_DONE;
            err_d   = bad;
            rdata_d = 32'h0;
          end else begin
            state_d     = S_REQ;
            cnt_d       = '0;
            req_addr_d  = {addr[31:2], 2'b00};
            req_wen_d   = !st_none;
            req_wdata_d = st_data;
            req_wmask_d = st_mask;
          end
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + CW'(1);
        if (tmo) begin
          state_d = S_DONE;
          err_d   = 1'b1;
          rdata_d = 32'h0;
        end else if (mem_req_ready) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        cnt_d = cnt_q + CW'(1);
        if (mem_resp_valid) begin
          state_d = S_DONE;
          err_d   = 1'b0;
          rdata_d = ld_data;
        end else if (tmo) begin
          state_d = S_DONE;
          err_d   = 1'b1;
          rdata_d = 32'h0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      ld_q        <= 3'b111;
      off_q       <= 2'b00;
      req_addr_q  <= 32'h0;
      req_wen_q   <= 1'b0;
      req_wdata_q <= 32'h0;
      req_wmask_q <= 4'h0;
      rdata_q     <= 32'h0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ld_q        <= ld_d;
      off_q       <= off_d;
      req_addr_q  <= req_addr_d;
      req_wen_q   <= req_wen_d;
      req_wdata_q <= req_wdata_d;
      req_wmask_q <= req_wmask_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  assign in_ready      = state_q == S_IDLE;
  assign out_valid     = state_q == S_DONE;
  assign out_rdata     = rdata_q;
  assign out_err       = err_q;
  assign mem_req_valid = state_q == S_REQ;
  assign mem_req_addr  = req_addr_q;
  assign mem_req_wen   = req_wen_q;
  assign mem_req_wdata = req_wdata_q;
  assign mem_req_wmask = req_wmask_q;

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Bench for lsu_bus_ctrl: directed vector table, corner sequences and
// random accesses checked against a rule-level reference model.
module tb_lsu_bus_ctrl;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] addr;
  logic [2:0]  is_load;
  logic [2:0]  is_store;
  logic [31:0] wdata;
  logic        out_valid;
  logic [31:0] out_rdata;
  logic        out_err;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_wen;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;

  int checks = 0;
  int failures = 0;

  lsu_bus_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .addr(addr),
    .is_load(is_load),
    .is_store(is_store),
    .wdata(wdata),
    .out_valid(out_valid),
    .out_rdata(out_rdata),
    .out_err(out_err),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen),
    .mem_req_wdata(mem_req_wdata),
    .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_rdata(mem_resp_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  ld;
    logic [2:0]  st;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rsp;
    logic        bus;
    logic        err;
    logic [3:0]  mask;
    logic [31:0] wdat;
    logic [31:0] rdat;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Expected outcome from the access rules, using plain arithmetic.
  function automatic vec_t model(input logic [2:0] ld,
                                 input logic [2:0] st,
                                 input logic [31:0] a,
                                 input logic [31:0] wd,
                                 input logic [31:0] rsp);
    vec_t v;
    int sz;
    int off;
    logic [31:0] sh;
    v.ld = ld; v.st = st; v.a = a; v.wd = wd; v.rsp = rsp;
    v.bus = 0; v.err = 0; v.mask = 0; v.wdat = 0; v.rdat = 0;
    off = int'(a[1:0]);
    if (ld == 7 && st == 7) return v;
    sz = 0;
    if (st == 7) begin
      case (ld)
        3'd0, 3'd4: sz = 1;
        3'd1, 3'd5: sz = 2;
        3'd2:       sz = 4;
        default:    sz = 0;
      endcase
    end else if (ld == 7) begin
      case (st)
        3'd0:    sz = 1;
        3'd1:    sz = 2;
        3'd2:    sz = 4;
        default: sz = 0;
      endcase
    end
    if (sz == 0 || (off % sz) != 0) begin
      v.err = 1;
      return v;
    end
    v.bus = 1;
    if (st != 7) begin
      v.mask = 4'(((1 << sz) - 1) << off);
      if (sz == 1)      v.wdat = {4{wd[7:0]}};
      else if (sz == 2) v.wdat = {2{wd[15:0]}};
      else              v.wdat = wd;
    end else begin
      sh = rsp >> (8 * off);
      case (ld)
        3'd0: v.rdat = 32'(int'($signed(sh[7:0])));
        3'd4: v.rdat = 32'(sh[7:0]);
        3'd1: v.rdat = 32'(int'($signed(sh[15:0])));
        3'd5: v.rdat = 32'(sh[15:0]);
        default: v.rdat = rsp;
      endcase
    end
    return v;
  endfunction

  // rv/pv: bus ready / response value per cycle since entering REQ.
  task automatic run_access(input vec_t v, input logic [7:0] rv,
                            input logic [7:0] pv);
    int h;
    int r;
    int d;
    logic terr;
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    is_load = v.ld;
    is_store = v.st;
    addr = v.a;
    wdata = v.wd;
    mem_resp_rdata = v.rsp;
    @(negedge clk);
    in_valid = 1'b0;
    is_load = 3'b111;
    is_store = 3'b111;
    h = -1;
    r = -1;
    terr = 1'b0;
    d = 0;
    if (v.bus) begin
      for (int i = 0; i <= T - 2; i++)
        if (rv[i] && h < 0) h = i;
      if (h >= 0)
        for (int i = h + 1; i <= T - 1; i++)
          if (pv[i] && r < 0) r = i;
      if (r < 0) begin
        d = T;
        terr = 1'b1;
      end else begin
        d = r + 1;
      end
    end
    for (int j = 0; j <= T; j++) begin
      if (j == d) begin
        chk("out_valid_done", 32'(out_valid), 32'd1);
        chk("out_err", 32'(out_err), 32'(v.err | terr));
        chk("out_rdata", out_rdata, terr ? 32'h0 : v.rdat);
        break;
      end
      chk("out_valid_busy", 32'(out_valid), 32'd0);
      chk("in_ready_busy", 32'(in_ready), 32'd0);
      if (h < 0 || j <= h) begin
        chk("req_valid", 32'(mem_req_valid), 32'd1);
        chk("req_addr", mem_req_addr, {v.a[31:2], 2'b00});
        chk("req_wen", 32'(mem_req_wen), 32'(v.mask != 0));
        chk("req_wmask", 32'(mem_req_wmask), 32'(v.mask));
        if (v.mask != 0)
          chk("req_wdata", mem_req_wdata, v.wdat);
      end else begin
        chk("req_valid_resp", 32'(mem_req_valid), 32'd0);
      end
      mem_req_ready = rv[j];
      mem_resp_valid = pv[j];
      @(negedge clk);
    end
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0;
    @(negedge clk);
    chk("out_valid_after", 32'(out_valid), 32'd0);
    chk("in_ready_after", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    logic [2:0] lds[5];
    logic [7:0] rv;
    logic [7:0] pv;
    lds = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    tbl[0]  = '{3'd2, 3'd7, 32'h80000104, 32'h0, 32'hDEADBEEF,
                1'b1, 1'b0, 4'h0, 32'h0, 32'hDEADBEEF};
    tbl[1]  = '{3'd7, 3'd0, 32'h80000013, 32'hA5, 32'h0,
                1'b1, 1'b0, 4'h8, 32'hA5A5A5A5, 32'h0};
    tbl[2]  = '{3'd0, 3'd7, 32'h80000002, 32'h0, 32'h0080FF00,
                1'b1, 1'b0, 4'h0, 32'h0, 32'hFFFFFF80};
    tbl[3]  = '{3'd4, 3'd7, 32'h80000002, 32'h0, 32'h0080FF00,
                1'b1, 1'b0, 4'h0, 32'h0, 32'h00000080};
    tbl[4]  = '{3'd5, 3'd7, 32'h80000002, 32'h0, 32'h80010000,
                1'b1, 1'b0, 4'h0, 32'h0, 32'h00008001};
    tbl[5]  = '{3'd1, 3'd7, 32'h80000002, 32'h0, 32'h80010000,
                1'b1, 1'b0, 4'h0, 32'h0, 32'hFFFF8001};
    tbl[6]  = '{3'd1, 3'd7, 32'h80000001, 32'h0, 32'h0,
                1'b0, 1'b1, 4'h0, 32'h0, 32'h0};
    tbl[7]  = '{3'd2, 3'd2, 32'h80000000, 32'h0, 32'h0,
                1'b0, 1'b1, 4'h0, 32'h0, 32'h0};
    tbl[8]  = '{3'd7, 3'd7, 32'h80000000, 32'h0, 32'h0,
                1'b0, 1'b0, 4'h0, 32'h0, 32'h0};
    tbl[9]  = '{3'd7, 3'd1, 32'h80000006, 32'h1234BEEF, 32'h0,
                1'b1, 1'b0, 4'hC, 32'hBEEFBEEF, 32'h0};
    tbl[10] = '{3'd7, 3'd2, 32'h0000000C, 32'h11223344, 32'h0,
                1'b1, 1'b0, 4'hF, 32'h11223344, 32'h0};
    tbl[11] = '{3'd3, 3'd7, 32'h00000000, 32'h0, 32'h0,
                1'b0, 1'b1, 4'h0, 32'h0, 32'h0};
    tbl[12] = '{3'd7, 3'd5, 32'h00000000, 32'h0, 32'h0,
                1'b0, 1'b1, 4'h0, 32'h0, 32'h0};
    tbl[13] = '{3'd2, 3'd7, 32'h00000002, 32'h0, 32'h0,
                1'b0, 1'b1, 4'h0, 32'h0, 32'h0};
    tbl[14] = '{3'd7, 3'd1, 32'h00000001, 32'h0, 32'h0,
                1'b0, 1'b1, 4'h0, 32'h0, 32'h0};
    tbl[15] = '{3'd0, 3'd7, 32'h00000003, 32'h0, 32'h7F000000,
                1'b1, 1'b0, 4'h0, 32'h0, 32'h0000007F};

    rst = 1'b0;
    in_valid = 1'b0;
    addr = 32'h0;
    is_load = 3'b111;
    is_store = 3'b111;
    wdata = 32'h0;
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_rdata = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_out_rdata", out_rdata, 32'h0);
    chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_req_wen", 32'(mem_req_wen), 32'd0);
    chk("rst_req_addr", mem_req_addr, 32'h0);
    chk("rst_req_wdata", mem_req_wdata, 32'h0);
    chk("rst_req_wmask", 32'(mem_req_wmask), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Response also raised during the handshake cycle must be ignored.
    for (int k = 0; k < 16; k++)
      run_access(tbl[k], 8'h01, 8'h03);

    // Three stalled request cycles, then no response: timeout.
    run_access(tbl[0], 8'h08, 8'h00);
    mem_resp_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("late_resp_valid", 32'(out_valid), 32'd0);
      chk("late_resp_ready", 32'(in_ready), 32'd1);
      chk("late_resp_err", 32'(out_err), 32'd1);
    end
    mem_resp_valid = 1'b0;

    // Reset while waiting for the response abandons the access.
    in_valid = 1'b1;
    is_load = 3'd2;
    addr = 32'h80000200;
    @(negedge clk);
    in_valid = 1'b0;
    is_load = 3'b111;
    chk("rr_req_valid", 32'(mem_req_valid), 32'd1);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    chk("rr_in_resp", 32'(mem_req_valid), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rr_in_ready", 32'(in_ready), 32'd1);
    chk("rr_out_valid", 32'(out_valid), 32'd0);
    chk("rr_req_valid0", 32'(mem_req_valid), 32'd0);
    rst = 1'b1;
    mem_resp_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rr_no_pulse", 32'(out_valid), 32'd0);
    end
    mem_resp_valid = 1'b0;
    @(negedge clk);

    for (int n = 0; n < 200; n++) begin
      logic [2:0] ld;
      logic [2:0] st;
      case ($urandom % 4)
        0, 3: begin
          ld = lds[$urandom % 5];
          st = 3'b111;
        end
        1: begin
          ld = 3'b111;
          st = 3'($urandom % 3);
        end
        default: begin
          ld = 3'($urandom);
          st = 3'($urandom);
        end
      endcase
      v = model(ld, st, $urandom, $urandom, $urandom);
      rv = 8'($urandom);
      pv = 8'($urandom);
      if ($urandom % 8 == 0) rv = 8'h00;
      run_access(v, rv, pv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
